// File: rtl/iob_gpio_in_cond_pkg.sv
// Shared definitions for the GPIO input conditioner: default widths,
// register word indices and register reset values.
package iob_gpio_in_cond_pkg;

   localparam int unsigned GPIO_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DEB_W_DEF  = 16;

   // Word index of each register (byte address >> 2)
   typedef enum logic [2:0] {
      REG_DEB_CYCLES = 3'd0,
      REG_RISE_EN    = 3'd1,
      REG_FALL_EN    = 3'd2,
      REG_IRQ_EN     = 3'd3,
      REG_VALUE      = 3'd4,
      REG_EVENT      = 3'd5
   } reg_idx_e;

   localparam logic [ADDR_W_DEF-1:0] ADDR_DEB_CYCLES = 5'h00;
   localparam logic [ADDR_W_DEF-1:0] ADDR_RISE_EN    = 5'h04;
   localparam logic [ADDR_W_DEF-1:0] ADDR_FALL_EN    = 5'h08;
   localparam logic [ADDR_W_DEF-1:0] ADDR_IRQ_EN     = 5'h0C;
   localparam logic [ADDR_W_DEF-1:0] ADDR_VALUE      = 5'h10;
   localparam logic [ADDR_W_DEF-1:0] ADDR_EVENT      = 5'h14;

   localparam logic [DATA_W_DEF-1:0] RST_DEB_CYCLES = 32'h0;
   localparam logic [DATA_W_DEF-1:0] RST_RISE_EN    = 32'h0;
   localparam logic [DATA_W_DEF-1:0] RST_FALL_EN    = 32'h0;
   localparam logic [DATA_W_DEF-1:0] RST_IRQ_EN     = 32'h0;
   localparam logic [DATA_W_DEF-1:0] RST_EVENT      = 32'h0;

endpackage

// File: rtl/iob_gpio_debounce.sv
// One input pin: 2-flop synchronizer, programmable debounce counter and
// stable-level flop, with single-cycle rise/fall strobes.
module iob_gpio_debounce
   import iob_gpio_in_cond_pkg::*;
#(
   parameter int unsigned DEB_W = DEB_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_pin,
   input  logic [DEB_W-1:0] i_deb_cycles,
   output logic             o_stable,
   output logic             o_rise_c,
   output logic             o_fall_c
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [DEB_W-1:0] r_cnt;

   logic w_diff;
   logic w_done;
   logic w_cnt_max;

   assign w_diff    = r_sync2 ^ r_stable;
   // >= lets a lowered threshold complete an in-flight count immediately
   assign w_done    = w_diff & (r_cnt >= i_deb_cycles);
   assign w_cnt_max = &r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else if (!w_cnt_max) begin
            r_cnt <= r_cnt + DEB_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise_c = w_done & r_sync2;
   assign o_fall_c = w_done & ~r_sync2;

endmodule

// File: rtl/iob_gpio_in_cond.sv
// GPIO input conditioner: per-pin synchronize/debounce, sticky edge events
// with W1C clear, masked level interrupt, IOb native slave register file.
module iob_gpio_in_cond
   import iob_gpio_in_cond_pkg::*;
#(
   parameter int unsigned GPIO_W = GPIO_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEB_W  = DEB_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   input  logic [GPIO_W-1:0]   gpio_input,
   output logic [GPIO_W-1:0]   gpio_value,
   output logic                irq
);

   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam int unsigned NB    = DATA_W / 8;

   logic [DEB_W-1:0]  r_deb_cycles;
   logic [GPIO_W-1:0] r_rise_en;
   logic [GPIO_W-1:0] r_fall_en;
   logic [GPIO_W-1:0] r_irq_en;
   logic [GPIO_W-1:0] r_event;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ready;
   logic              r_irq;

   logic [IDX_W-1:0]  w_idx;
   logic              w_wr;
   logic              w_rd;
   logic [DATA_W-1:0] w_bmask;
   logic [DATA_W-1:0] w_wbits;
   logic [DATA_W-1:0] w_rdata;
   logic [GPIO_W-1:0] w_stable;
   logic [GPIO_W-1:0] w_rise;
   logic [GPIO_W-1:0] w_fall;
   logic [GPIO_W-1:0] w_set;
   logic [GPIO_W-1:0] w_clr;
   logic              w_unused_addr;

   assign w_unused_addr = ^address[1:0];
   assign w_idx         = address[ADDR_W-1:2];
   assign w_wr          = valid & (|wstrb);
   assign w_rd          = valid & ~(|wstrb);

   for (genvar b = 0; b < NB; b++) begin : g_bmask
      assign w_bmask[8*b +: 8] = {8{wstrb[b]}};
   end

   assign w_wbits = wdata & w_bmask;

   // Byte-strobed update of a register zero-extended to the bus width
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_val,
                                               input logic [DATA_W-1:0] bmask,
                                               input logic [DATA_W-1:0] wbits);
      return (old_val & ~bmask) | wbits;
   endfunction

   for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
      iob_gpio_debounce #(
         .DEB_W (DEB_W)
      ) u_deb (
         .clk          (clk),
         .rst          (rst),
         .i_pin        (gpio_input[i]),
         .i_deb_cycles (r_deb_cycles),
         .o_stable     (w_stable[i]),
         .o_rise_c     (w_rise[i]),
         .o_fall_c     (w_fall[i])
      );
   end

   assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
   assign w_clr = (w_wr && (w_idx == IDX_W'(REG_EVENT))) ? w_wbits[GPIO_W-1:0] : '0;

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         IDX_W'(REG_DEB_CYCLES): w_rdata = DATA_W'(r_deb_cycles);
         IDX_W'(REG_RISE_EN):    w_rdata = DATA_W'(r_rise_en);
         IDX_W'(REG_FALL_EN):    w_rdata = DATA_W'(r_fall_en);
         IDX_W'(REG_IRQ_EN):     w_rdata = DATA_W'(r_irq_en);
         IDX_W'(REG_VALUE):      w_rdata = DATA_W'(w_stable);
         IDX_W'(REG_EVENT):      w_rdata = DATA_W'(r_event);
         default:                w_rdata = '0;
      endcase
   end

   // Config registers; writes to VALUE or unmapped words fall through
   always_ff @(posedge clk) begin
      if (rst) begin
         r_deb_cycles <= RST_DEB_CYCLES[DEB_W-1:0];
         r_rise_en    <= RST_RISE_EN[GPIO_W-1:0];
         r_fall_en    <= RST_FALL_EN[GPIO_W-1:0];
         r_irq_en     <= RST_IRQ_EN[GPIO_W-1:0];
      end else if (w_wr) begin
         case (w_idx)
            IDX_W'(REG_DEB_CYCLES):
               r_deb_cycles <= DEB_W'(merge(DATA_W'(r_deb_cycles), w_bmask, w_wbits));
            IDX_W'(REG_RISE_EN):
               r_rise_en <= GPIO_W'(merge(DATA_W'(r_rise_en), w_bmask, w_wbits));
            IDX_W'(REG_FALL_EN):
               r_fall_en <= GPIO_W'(merge(DATA_W'(r_fall_en), w_bmask, w_wbits));
            IDX_W'(REG_IRQ_EN):
               r_irq_en <= GPIO_W'(merge(DATA_W'(r_irq_en), w_bmask, w_wbits));
            default: ;
         endcase
      end
   end

   // Sticky events: a new edge in the same cycle as its W1C keeps the bit set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_event <= RST_EVENT[GPIO_W-1:0];
         r_irq   <= 1'b0;
      end else begin
         r_event <= (r_event & ~w_clr) | w_set;
         r_irq   <= |(r_event & r_irq_en);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= valid;
         r_rdata <= w_rd ? w_rdata : '0;
      end
   end

   assign rdata      = r_rdata;
   assign ready      = r_ready;
   assign irq        = r_irq;
   assign gpio_value = w_stable;

endmodule
